tmp_sample_ctrl: RTL and testbench

Periodic read scheduler and smoothing stage for the on-board 13-bit temperature sensor path. It issues one read request to the sensor read engine every sample period and supervises the done/timeout handshake. It averages the last 2^AVG_LOG2 readings and presents a stable 13-bit `temp_o`, in 1/16 °C units, to the temperature translate/display block. The block sits between the I2C read engine and the digit/RGB translation logic.

---
 rtl/tmp_pkg.sv | 21 ++
 rtl/tmp_avg.sv | 67 ++++++
 rtl/tmp_sample_ctrl.sv | 133 +++++++++++++
 tb/tb_tmp_sample_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_pkg.sv
// Shared types and constants for the temperature sample controller.
package tmp_pkg;

  localparam int TEMP_W  = 13;
  localparam int RAW_MSB = 15;
  localparam int RAW_LSB = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    UPDATE,
    WAIT_PERIOD
  } tmp_state_t;

  // Sample period expressed in clock cycles.
  function automatic int calc_period(input int clk_hz, input int sample_ms);
    return (clk_hz / 1000) * sample_ms;
  endfunction

endpackage

// File: rtl/tmp_avg.sv
// Moving-average stage: ring of the last 2^AVG_LOG2 samples with a running
// signed sum. The first accepted sample preloads every ring entry so the
// output is meaningful immediately.
module tmp_avg
  import tmp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [TEMP_W-1:0] din,
  output logic [TEMP_W-1:0] dout,
  output logic              valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int SW    = TEMP_W + AVG_LOG2;

  logic [TEMP_W-1:0]    ring [DEPTH];
  logic [PW-1:0]        ptr;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_next;
  logic signed [SW-1:0] din_ext;
  logic signed [SW-1:0] old_ext;

  // Next running sum: preload on the first sample, else swap oldest for newest.
  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    din_ext  = SW'($signed(din));
    old_ext  = SW'($signed(ring[ptr]));
    sum_next = sum;
    if (!valid) sum_next = din_ext <<< AVG_LOG2;
    else        sum_next = sum - old_ext + din_ext;
  end

  // Sum, pointer, output and valid flag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst) begin
      sum   <= '0;
      ptr   <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      sum   <= sum_next;
      dout  <= TEMP_W'(sum_next >>> AVG_LOG2);
      valid <= 1'b1;
      if (valid) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

  // Sample ring storage.
  // NOTE: the ring has no reset; the first-sample preload overwrites every entry
  // before any of them is read into the sum.
  always_ff @(posedge clk) begin
    if (wr) begin
      if (!valid) begin
        for (int i = 0; i < DEPTH; i++) ring[i] <= din;
      end else begin
        ring[ptr] <= din;
      end
    end
  end

endmodule

// File: rtl/tmp_sample_ctrl.sv
// Periodic sensor read scheduler: issues one read per sample period, watches
// the done/timeout handshake, counts timeouts and feeds the averager.
module tmp_sample_ctrl
  import tmp_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_MS   = 250,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int AVG_LOG2    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_busy,
  input  logic              rd_done,
  input  logic [15:0]       rd_data,
  output logic              rd_start,
  output logic [TEMP_W-1:0] temp_o,
  output logic              temp_valid,
  output logic              temp_upd,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int PERIOD = calc_period(CLK_HZ, SAMPLE_MS);
  localparam int PCW    = $clog2(PERIOD + 1);
  localparam int TCW    = $clog2(TIMEOUT_CYC + 1);

  tmp_state_t        state, state_next;
  logic [PCW-1:0]    pcnt;
  logic [TCW-1:0]    tcnt;
  logic [TEMP_W-1:0] sample;
  logic              issue, capture, timeout;
  logic              rd_start_next, err_next, upd_next;
  logic              unused_raw_bits;

  // The fractional sub-LSB bits of the sensor register carry no temperature.
  assign unused_raw_bits = ^rd_data[RAW_LSB-1:0];

  assign timeout = (tcnt == TCW'(TIMEOUT_CYC - 1));

  // Next state and next registered-output values.
  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    capture       = 1'b0;
    rd_start_next = 1'b0;
    err_next      = 1'b0;
    upd_next      = 1'b0;
    case (state)
      IDLE: if (en) state_next = ISSUE;
      ISSUE: begin
        if (!en) begin
          state_next = IDLE;
        end else if (!rd_busy) begin
          issue         = 1'b1;
          rd_start_next = 1'b1;
          state_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A done in the final timeout cycle still counts as a good read.
        if (rd_done) begin
          capture    = 1'b1;
          state_next = UPDATE;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = en ? WAIT_PERIOD : IDLE;
        end
      end
      UPDATE: begin
        upd_next   = 1'b1;
        state_next = en ? WAIT_PERIOD : IDLE;
      end
      WAIT_PERIOD: begin
        if (!en)                             state_next = IDLE;
        else if (pcnt == PCW'(PERIOD - 1))   state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_start <= 1'b0;
      err      <= 1'b0;
      temp_upd <= 1'b0;
    end else begin
      state    <= state_next;
      rd_start <= rd_start_next;
      err      <= err_next;
      temp_upd <= upd_next;
    end
  end

  // Period counter: the issue cycle is count 0, so issues land PERIOD apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              pcnt <= '0;
    else if (issue)                       pcnt <= PCW'(1);
    else if (state == IDLE)               pcnt <= '0;
    else if (pcnt != PCW'(PERIOD - 1))    pcnt <= pcnt + PCW'(1);
  end

  // Timeout counter, running only while a read is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   tcnt <= '0;
    else if (issue)                            tcnt <= '0;
    else if (state == WAIT_DONE && !timeout)   tcnt <= tcnt + TCW'(1);
  end

  // Saturating timeout count and captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      sample  <= '0;
    end else begin
      if (err_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (capture)                      sample  <= rd_data[RAW_MSB:RAW_LSB];
    end
  end

  tmp_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk   (clk),
    .rst   (rst),
    .wr    (state == UPDATE),
    .din   (sample),
    .dout  (temp_o),
    .valid (temp_valid)
  );

endmodule

// File: tb/tb_tmp_sample_ctrl.sv
// Bench for tmp_sample_ctrl: table-driven averaging vectors, directed
// timeout/busy/disable/reset sequences and a randomized run against a
// queue-based moving-average model.
module tb_tmp_sample_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int SAMPLE_MS   = 10;
  localparam int TIMEOUT_CYC = 5;
  localparam int AVG_LOG2    = 2;
  localparam int PERIOD      = 10;
  localparam int N           = 4;

  logic        clk = 1'b0;
  logic        rst, en, rd_busy, rd_done;
  logic [15:0] rd_data;
  logic        rd_start, temp_valid, temp_upd, err;
  logic [12:0] temp_o;
  logic [7:0]  err_cnt;

  tmp_sample_ctrl #(
    .CLK_HZ(CLK_HZ), .SAMPLE_MS(SAMPLE_MS),
    .TIMEOUT_CYC(TIMEOUT_CYC), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_data(rd_data), .rd_start(rd_start), .temp_o(temp_o),
    .temp_valid(temp_valid), .temp_upd(temp_upd), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit fresh; int sample; int exp; } vec_t;
  typedef struct { bit is_err; int val; } outcome_t;

  int total = 0;
  int bad   = 0;

  // responder / monitor state
  int       cyc_n = 0;
  bit       reply, rand_mode, mon, cad_chk, armed, mvalid;
  int       dly = 2, cd, prev_start = -1, last_start = -1, last_done = -1;
  int       n_start = 0, n_upd = 0, n_err = 0, exp_errs = 0;
  logic [15:0] pend;
  int       feed_q[$];
  int       hist[$];
  outcome_t out_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_raw(input int s);
    logic [12:0] t;
    t = 13'(s);
    return {t, 3'b000};
  endfunction

  // Floor of the mean of the last N accepted samples.
  function automatic int model_push(input int s);
    int sum, q;
    if (!mvalid) begin
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(s);
      mvalid = 1'b1;
    end else begin
      void'(hist.pop_front());
      hist.push_back(s);
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    q = sum / N;
    if (sum < 0 && (sum % N) != 0) q -= 1;
    return q;
  endfunction

  // One clock: observe outputs #1 after the edge, then drive the responder.
  task automatic cyc();
    outcome_t o;
    int s;
    @(posedge clk);
    #1;
    cyc_n++;
    rd_done = 1'b0;
    if (mon && (temp_upd || err)) begin
      if (out_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rand_unexpected_event: cycle %0d upd=%0b err=%0b", cyc_n, temp_upd, err);
      end else begin
        o = out_q.pop_front();
        if (o.is_err) begin
          check("rand_err_kind", err, 1);
          check("rand_err_cnt", err_cnt, o.val);
        end else begin
          check("rand_upd_kind", temp_upd, 1);
          check("rand_temp", $signed(temp_o), o.val);
          check("rand_upd_latency", cyc_n - last_done, 2);
        end
      end
    end
    if (temp_upd) n_upd++;
    if (err) n_err++;
    if (rd_start) begin
      n_start++;
      if (cad_chk && prev_start >= 0) check("cadence", cyc_n - prev_start, PERIOD);
      prev_start = cyc_n;
      last_start = cyc_n;
      if (reply) begin
        if (rand_mode) begin
          dly = $urandom_range(0, 6);
          s   = int'($urandom_range(0, 8191));
          if (s >= 4096) s -= 8192;
          pend = to_raw(s) | 16'($urandom_range(0, 7));
          if (dly <= TIMEOUT_CYC - 1) begin
            o.is_err = 1'b0; o.val = model_push(s);
          end else begin
            exp_errs++;
            o.is_err = 1'b1; o.val = (exp_errs > 255) ? 255 : exp_errs;
          end
          out_q.push_back(o);
        end else begin
          s = (feed_q.size() != 0) ? feed_q.pop_front() : 0;
          pend = to_raw(s);
        end
        armed = 1'b1;
        cd    = dly;
      end
    end else if (armed) begin
      cd--;
    end
    if (armed && cd == 0) begin
      rd_done   = 1'b1;
      rd_data   = pend;
      armed     = 1'b0;
      last_done = cyc_n;
    end
  endtask

  // which: 0 = rd_start, 1 = temp_upd, 2 = err
  task automatic wait_ev(input int which, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if ((which == 0 && rd_start) || (which == 1 && temp_upd) || (which == 2 && err)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rd_busy = 1'b0; rd_done = 1'b0; rd_data = '0;
    reply = 1'b0; armed = 1'b0; mvalid = 1'b0; prev_start = -1;
    feed_q.delete();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic enable();
    prev_start = -1;
    en = 1'b1;
  endtask

  vec_t vecs[11];

  initial begin
    bit ok;
    int e, s0, s1, ns, nu;

    vecs = '{
      '{1'b1,   400,   400}, '{1'b0,   416,   404}, '{1'b0,   432,   412},
      '{1'b0,   448,   424}, '{1'b0,   464,   440},
      '{1'b1,   -16,   -16}, '{1'b0,   -15,   -16}, '{1'b0,    -1,   -12},
      '{1'b0,     7,    -7},
      '{1'b1, -4096, -4096}, '{1'b0,  4095, -2049}
    };

    do_reset();
    cyc();
    check("reset_rd_start", rd_start, 0);
    check("reset_temp_o", temp_o, 0);
    check("reset_temp_valid", temp_valid, 0);
    check("reset_temp_upd", temp_upd, 0);
    check("reset_err", err, 0);
    check("reset_err_cnt", err_cnt, 0);

    // Table: cadence, first-issue latency, averaging and floor rounding.
    cad_chk = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].fresh) begin
        do_reset();
        check($sformatf("tbl%0d_valid_before", i), temp_valid, 0);
        feed_q.push_back(vecs[i].sample);
        reply = 1'b1; dly = 2;
        enable();
        e = cyc_n;
        wait_ev(0, 10, ok);
        check($sformatf("tbl%0d_start_seen", i), ok, 1);
        if (ok) check($sformatf("tbl%0d_start_latency", i), cyc_n - e, 2);
      end else begin
        feed_q.push_back(vecs[i].sample);
      end
      wait_ev(1, 2 * PERIOD, ok);
      check($sformatf("tbl%0d_upd_seen", i), ok, 1);
      if (ok) begin
        check($sformatf("tbl%0d_temp", i), $signed(temp_o), vecs[i].exp);
        check($sformatf("tbl%0d_valid", i), temp_valid, 1);
        check($sformatf("tbl%0d_upd_latency", i), cyc_n - last_done, 2);
      end
    end

    // Timeout: no done is ever returned.
    reply = 1'b0;
    wait_ev(0, 2 * PERIOD, ok);
    check("to_start_seen", ok, 1);
    wait_ev(2, 2 * PERIOD, ok);
    check("to_err_seen", ok, 1);
    check("to_err_latency", cyc_n - last_start, TIMEOUT_CYC);
    check("to_err_cnt_first", err_cnt, 1);
    cyc();
    check("to_err_pulse_width", err, 0);
    check("to_temp_held", $signed(temp_o), -2049);
    repeat (300 * PERIOD) cyc();
    check("to_err_cnt_saturated", err_cnt, 255);
    check("to_temp_held_long", $signed(temp_o), -2049);
    check("to_valid_held", temp_valid, 1);

    // Busy at a scheduled issue: start slips until busy falls, no duplicate.
    wait_ev(0, 2 * PERIOD, ok);
    check("busy_ref_start_seen", ok, 1);
    s0 = last_start;
    cad_chk = 1'b0;
    while (cyc_n < s0 + 9) cyc();
    rd_busy = 1'b1;
    ns = n_start;
    while (cyc_n < s0 + 16) cyc();
    rd_busy = 1'b0;
    wait_ev(0, 5, ok);
    check("busy_start_seen", ok, 1);
    check("busy_start_cycle", last_start - s0, 17);
    check("busy_single_start", n_start - ns, 1);
    s1 = last_start;
    prev_start = s1;
    cad_chk = 1'b1;

    // Stray done in WAIT_PERIOD is ignored.
    wait_ev(2, 2 * PERIOD, ok);
    check("late_err_seen", ok, 1);
    cyc();
    rd_done = 1'b1;
    rd_data = to_raw(100);
    nu = n_upd;
    repeat (4) cyc();
    check("late_no_upd", n_upd - nu, 0);
    check("late_temp_held", $signed(temp_o), -2049);

    // Drop en in WAIT_DONE: read completes, then idle.
    do_reset();
    feed_q.push_back(800);
    reply = 1'b1; dly = 2;
    enable();
    wait_ev(0, 5, ok);
    check("dis_start_seen", ok, 1);
    en = 1'b0;
    wait_ev(1, 10, ok);
    check("dis_upd_seen", ok, 1);
    check("dis_temp", $signed(temp_o), 800);
    ns = n_start;
    repeat (3 * PERIOD) cyc();
    check("dis_no_start", n_start - ns, 0);
    check("dis_temp_held", $signed(temp_o), 800);
    check("dis_valid_held", temp_valid, 1);

    // Reset in WAIT_DONE clears everything at once; late done ignored.
    reply = 1'b0;
    enable();
    wait_ev(2, 3 * PERIOD, ok);
    check("rst_err_seen", ok, 1);
    check("rst_err_cnt_pre", err_cnt, 1);
    wait_ev(0, 2 * PERIOD, ok);
    check("rst_start_seen", ok, 1);
    rst = 1'b1;
    #1;
    check("rst_async_rd_start", rd_start, 0);
    check("rst_async_temp_o", temp_o, 0);
    check("rst_async_valid", temp_valid, 0);
    check("rst_async_upd", temp_upd, 0);
    check("rst_async_err", err, 0);
    check("rst_async_err_cnt", err_cnt, 0);
    en = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    rd_done = 1'b1;
    rd_data = to_raw(300);
    nu = n_upd; ns = n_start;
    repeat (5) cyc();
    check("rst_late_no_upd", n_upd - nu, 0);
    check("rst_late_valid", temp_valid, 0);
    check("rst_late_no_start", n_start - ns, 0);

    // Randomized run against the reference model.
    do_reset();
    out_q.delete();
    exp_errs = 0;
    reply = 1'b1; rand_mode = 1'b1; mon = 1'b1; cad_chk = 1'b1;
    enable();
    repeat (40 * PERIOD) cyc();
    en = 1'b0;
    repeat (2 * PERIOD) cyc();
    check("rand_all_events_seen", out_q.size(), 0);
    mon = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1);
  end

endmodule
